// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: drains dirty-line evictions and fetches missing lines between a two-port data cache and the memory bus
// Ports: miss1_*/miss2_* level miss requests with 1-cycle acks; wb_* eviction push (valid/ready);
// bus_req_* burst request, bus_w* write beats, bus_r* read beats; fill_* zero-latency refill words.
module dcache_refill_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int WB_DEPTH = 2,
  parameter int ADDR_W = 64,
  localparam int IDX_W = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss1_req,
  input  logic [ADDR_W-1:0]        miss1_addr,
  input  logic                     miss2_req,
  input  logic [ADDR_W-1:0]        miss2_addr,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [LINE_WORDS*64-1:0] wb_line,
  output logic                     bus_req_valid,
  input  logic                     bus_req_ready,
  output logic                     bus_req_write,
  output logic [ADDR_W-1:0]        bus_req_addr,
  output logic                     bus_wvalid,
  input  logic                     bus_wready,
  output logic [63:0]              bus_wdata,
  output logic                     bus_wlast,
  input  logic                     bus_rvalid,
  input  logic [63:0]              bus_rdata,
  output logic                     fill_valid,
  output logic [1:0]               fill_port,
  output logic [ADDR_W-1:0]        fill_addr,
  output logic [IDX_W-1:0]         fill_idx,
  output logic [63:0]              fill_data,
  output logic                     miss1_ack,
  output logic                     miss2_ack
);
  localparam int PW = WB_DEPTH > 1 ? $clog2(WB_DEPTH) : 1;
  localparam int CW = $clog2(WB_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_DATA, RD_REQ, RD_DATA, ACK} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [1:0] port_q, port_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WB_DEPTH-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] fifo_addr_q [WB_DEPTH];
  logic [LINE_WORDS*64-1:0] fifo_line_q [WB_DEPTH];
  logic [ADDR_W-1:0] line1, line2, head_addr;
  logic [LINE_WORDS*64-1:0] head_line;
  logic full, push, pop, hazard;
  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_WORDS * 8 - 1);
  endfunction
  assign line1 = line_of(miss1_addr);
  assign line2 = line_of(miss2_addr);
  assign full = count_q == CW'(WB_DEPTH);
  assign wb_ready = !full;
  assign push = wb_valid && !full;
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_line = fifo_line_q[rd_ptr_q];
  // a pending miss to a line still sitting in the eviction buffer must wait for that line to reach memory
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++)
      hazard |= vld_q[i] && ((miss1_req && fifo_addr_q[i] == line1) || (miss2_req && fifo_addr_q[i] == line2));
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_addr_d = rd_addr_q;
    port_d = port_q;
    pop = 1'b0;
    case (state_q)
      IDLE:
        if (full || hazard) state_d = WB_REQ;
        else if (miss1_req || miss2_req) begin
          state_d = RD_REQ;
          rd_addr_d = miss1_req ? line1 : line2;
          port_d = miss1_req ? {miss2_req && line1 == line2, 1'b1} : 2'b10;
        end else if (|count_q) state_d = WB_REQ;
      WB_REQ:
        if (bus_req_ready) begin
          state_d = WB_DATA;
          cnt_d = '0;
        end
      WB_DATA:
        if (bus_wready) begin
          cnt_d = cnt_q + 1'b1;
          pop = &cnt_q;
          state_d = &cnt_q ? IDLE : WB_DATA;
        end
      RD_REQ:
        if (bus_req_ready) begin
          state_d = RD_DATA;
          cnt_d = '0;
        end
      RD_DATA:
        if (bus_rvalid) begin
          cnt_d = cnt_q + 1'b1;
          state_d = &cnt_q ? ACK : RD_DATA;
        end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q == PW'(WB_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == PW'(WB_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    vld_d = vld_q;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    if (pop) vld_d[rd_ptr_q] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_addr_q <= '0;
      port_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_addr_q <= rd_addr_d;
      port_q <= port_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      vld_q <= vld_d;
    end
  always_ff @(posedge clk)
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= line_of(wb_addr);
      fifo_line_q[wr_ptr_q] <= wb_line;
    end
  assign bus_req_valid = state_q == WB_REQ || state_q == RD_REQ;
  assign bus_req_write = state_q == WB_REQ;
  assign bus_req_addr = state_q == WB_REQ ? head_addr : state_q == RD_REQ ? rd_addr_q : '0;
  assign bus_wvalid = state_q == WB_DATA;
  assign bus_wdata = bus_wvalid ? head_line[{cnt_q, 6'd0} +: 64] : '0;
  assign bus_wlast = bus_wvalid && &cnt_q;
  assign fill_valid = state_q == RD_DATA && bus_rvalid;
  assign fill_port = fill_valid ? port_q : '0;
  assign fill_addr = fill_valid ? rd_addr_q : '0;
  assign fill_idx = fill_valid ? cnt_q : '0;
  assign fill_data = fill_valid ? bus_rdata : '0;
  assign miss1_ack = state_q == ACK && port_q[0];
  assign miss2_ack = state_q == ACK && port_q[1];
endmodule
